// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan chain controller: FSM states, default fill bit and the
// masked response compare.
package scan_ctrl_pkg;

  localparam int unsigned MaxChainLen = 1024;
  localparam logic        FillDefault = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StCapture,
    StShiftOut,
    StDone
  } scan_state_e;

  // Callers zero-extend to MaxChainLen so one function covers every chain length.
  function automatic logic masked_mismatch(input logic [MaxChainLen-1:0] resp,
                                           input logic [MaxChainLen-1:0] expv,
                                           input logic [MaxChainLen-1:0] mask);
    return |((resp ^ expv) & mask);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load shift register: shifts towards the MSB with the serial input entering bit 0.
module scan_shift_reg #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {data_q[Width-2:0], ser_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shifts a pattern in, pulses one capture, shifts the response out and
// compares it against a masked expected vector.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1),
  parameter logic        FILL      = FillDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CHAIN_LEN-1:0] pattern_i,
  input  logic [CHAIN_LEN-1:0] expect_i,
  input  logic [CHAIN_LEN-1:0] mask_i,
  output logic                 se_o,
  output logic                 si_o,
  input  logic                 so_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mismatch_o,
  output logic [CHAIN_LEN-1:0] response_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CHAIN_LEN - 1);

  scan_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 se_q, si_q, busy_q, done_q, mismatch_q;
  logic [CHAIN_LEN-1:0] response_q, exp_q, mask_q;

  logic                 accept, last, pat_shift, resp_shift;
  logic [CHAIN_LEN-1:0] pat_data, resp_data, resp_next;

  assign accept     = (state_q == StIdle) && start_i && !abort_i;
  assign last       = (cnt_q == LastCnt);
  assign pat_shift  = (state_q == StShiftIn);
  assign resp_shift = (state_q == StShiftOut);
  assign resp_next  = {resp_data[CHAIN_LEN-2:0], so_i};

  // The MSB goes straight to SI at accept, so the register holds the pattern pre-shifted by one.
  scan_shift_reg #(
    .Width(CHAIN_LEN)
  ) u_pattern_sr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .load_data_i({pattern_i[CHAIN_LEN-2:0], FILL}),
    .shift_i    (pat_shift),
    .ser_i      (FILL),
    .data_o     (pat_data)
  );

  scan_shift_reg #(
    .Width(CHAIN_LEN)
  ) u_response_sr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (1'b0),
    .load_data_i({CHAIN_LEN{1'b0}}),
    .shift_i    (resp_shift),
    .ser_i      (so_i),
    .data_o     (resp_data)
  );

  logic unused_bits;
  assign unused_bits = ^{pat_data[CHAIN_LEN-2:0], resp_data[CHAIN_LEN-1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      se_q       <= 1'b0;
      si_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      response_q <= '0;
      exp_q      <= '0;
      mask_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        se_q    <= 1'b0;
        si_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              state_q    <= StShiftIn;
              cnt_q      <= '0;
              exp_q      <= expect_i;
              mask_q     <= mask_i;
              mismatch_q <= 1'b0;
              busy_q     <= 1'b1;
              se_q       <= 1'b1;
              si_q       <= pattern_i[CHAIN_LEN-1];
            end
          end
          StShiftIn: begin
            if (last) begin
              state_q <= StCapture;
              cnt_q   <= '0;
              se_q    <= 1'b0;
              si_q    <= FILL;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              si_q  <= pat_data[CHAIN_LEN-1];
            end
          end
          StCapture: begin
            state_q <= StShiftOut;
            se_q    <= 1'b1;
            si_q    <= FILL;
          end
          StShiftOut: begin
            if (last) begin
              state_q    <= StDone;
              cnt_q      <= '0;
              se_q       <= 1'b0;
              si_q       <= 1'b0;
              done_q     <= 1'b1;
              response_q <= resp_next;
              mismatch_q <= masked_mismatch(MaxChainLen'(resp_next), MaxChainLen'(exp_q),
                                            MaxChainLen'(mask_q));
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign se_o       = se_q;
  assign si_o       = si_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mismatch_o = mismatch_q;
  assign response_o = response_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl driving an 8-flop scan chain whose functional D is ~Q; expected
// results come from a scoreboard fed by the stimulus and drained by a done-driven monitor.
module tb_scan_chain_ctrl;

  localparam int   L    = 8;
  localparam logic FILL = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, abort = 1'b0;
  logic [L-1:0] pattern = '0, expv = '0, mask = '0;
  logic         se, si, so, busy, done, mism;
  logic [L-1:0] resp;

  logic [L-1:0] chain = '0;
  int           cyc = 0;
  int           n_tests = 0, n_fail = 0;
  int           busy_run = 0;
  logic [L-1:0] last_resp = '0;
  logic         last_mism = 1'b0;

  typedef struct {
    logic [L-1:0] resp;
    logic         mism;
    int           acc;
  } exp_t;
  exp_t sb[$];
  exp_t mt;

  scan_chain_ctrl #(
    .CHAIN_LEN(L)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .abort_i   (abort),
    .pattern_i (pattern),
    .expect_i  (expv),
    .mask_i    (mask),
    .se_o      (se),
    .si_o      (si),
    .so_i      (so),
    .busy_o    (busy),
    .done_o    (done),
    .mismatch_o(mism),
    .response_o(resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain of sdffq cells: scan shifts flop k into k+1, functional capture inverts every flop.
  always @(posedge clk) begin
    if (se) chain <= {chain[L-2:0], si};
    else    chain <= ~chain;
  end
  assign so = chain[L-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else      busy_run = 0;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          mt = sb.pop_front();
          chk("response", 32'(resp), 32'(mt.resp));
          chk("mismatch", 32'(mism), 32'(mt.mism));
          // Done occupies the (2L+2)-th cycle after the accepting edge.
          chk("done_latency", 32'(cyc - mt.acc), 32'(2 * L + 1));
          chk("busy_len", 32'(busy_run), 32'(2 * L + 2));
        end
      end
    end
  end

  task automatic issue(input logic [L-1:0] p, input logic [L-1:0] e, input logic [L-1:0] m,
                       input bit spam);
    exp_t t;
    start   = 1'b1;
    pattern = p;
    expv    = e;
    mask    = m;
    @(negedge clk);
    t.resp = ~p;
    t.mism = |((~p ^ e) & m);
    t.acc  = cyc;
    sb.push_back(t);
    for (int c = 0; c < 2 * L + 2; c++) begin
      chk("busy", 32'(busy), 32'd1);
      chk("se_wave", 32'(se), 32'(c != L && c != 2 * L + 1));
      chk("si_wave", 32'(si), 32'((c < L) ? p[L-1-c] : FILL));
      if (c < 2 * L + 1) chk("mismatch_cleared", 32'(mism), 32'd0);
      start = spam;
      if (spam) begin
        pattern = L'($urandom);
        expv    = L'($urandom);
        mask    = L'($urandom);
      end
      @(negedge clk);
    end
    start     = 1'b0;
    last_resp = t.resp;
    last_mism = t.mism;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_se", 32'(se), 32'd0);
    chk("idle_si", 32'(si), 32'd0);
  endtask

  task automatic issue_abort(input logic [L-1:0] p, input logic [L-1:0] e,
                             input logic [L-1:0] m, input int at);
    start   = 1'b1;
    pattern = p;
    expv    = e;
    mask    = m;
    @(negedge clk);
    start = 1'b0;
    repeat (at) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    last_mism = 1'b0;
    chk("abort_se", 32'(se), 32'd0);
    chk("abort_si", 32'(si), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_resp", 32'(resp), 32'(last_resp));
    repeat (2 * L + 2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [L-1:0] p, e, m;
    #3;
    chk("rst_se", 32'(se), 32'd0);
    chk("rst_si", 32'(si), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mism", 32'(mism), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(8'hA5, 8'h5A, 8'hFF, 1'b0);
    issue(8'hA5, 8'h5B, 8'hFF, 1'b0);

    // start and abort together in IDLE: start is dropped, mismatch keeps its value
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_se", 32'(se), 32'd0);
    chk("start_abort_mism", 32'(mism), 32'(last_mism));

    issue(8'hA5, 8'h5B, 8'hFE, 1'b0);
    issue(8'h3C, 8'h00, 8'h00, 1'b0);
    issue(8'h01, 8'hFE, 8'hFF, 1'b0);
    issue_abort(8'hC3, 8'h3C, 8'hFF, 3);
    issue(8'h96, 8'h69, 8'hF0, 1'b1);
    issue(8'h0F, 8'hF1, 8'h0F, 1'b0);

    // async reset in shift-out cycle 2
    start   = 1'b1;
    pattern = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (L + 3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_se", 32'(se), 32'd0);
    chk("arst_si", 32'(si), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_mism", 32'(mism), 32'd0);
    chk("arst_resp", 32'(resp), 32'd0);
    #1 rst_n = 1'b1;
    last_resp = '0;
    last_mism = 1'b0;
    @(negedge clk);
    issue(8'hE7, 8'h18, 8'hFF, 1'b0);

    for (int i = 0; i < 30; i++) begin
      p = L'($urandom);
      m = ($urandom_range(0, 3) == 0) ? '0 : L'($urandom);
      e = ($urandom_range(0, 1) == 1) ? ~p : L'($urandom);
      if ($urandom_range(0, 4) == 0) issue_abort(p, e, m, $urandom_range(0, 2 * L));
      else                           issue(p, e, m, $urandom_range(0, 1) == 1);
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Controller that drives one scan chain built from sdffq cells (SE/SI/D/CLK/Q) and consumes the chain's tail output.
- Per start request it runs four steps: shift a stimulus pattern in, pulse one functional capture, shift the response out, then compare it against a masked expected vector.
- It sits directly upstream of the chain on SE and SI, and directly downstream of it on SO.
- Used for on-chip logic self-test and for bring-up of scan-inserted blocks.

Parameters:
- CHAIN_LEN, 16, number of scan flops in the chain (2..1024).
- CNT_W, $clog2(CHAIN_LEN+1), shift-counter width.
- FILL, 1'b0, value driven on SI while the response is shifted out.

Ports:
- CLK  input  1  clock; the same clock that drives the chain's CLK.
- RN  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; accepted only in IDLE.
- abort  input  1  synchronous abort; highest priority after reset.
- pattern  input  CHAIN_LEN  stimulus; pattern[k] is loaded into chain flop k.
- expect  input  CHAIN_LEN  expected captured response.
- mask  input  CHAIN_LEN  1 = compare this bit, 0 = ignore it.
- SE  output  1  scan enable to every chain flop (registered).
- SI  output  1  scan data into chain flop 0 (registered).
- SO  input  1  Q of chain flop CHAIN_LEN-1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at completion.
- mismatch  output  1  (response ^ expect) & mask is nonzero; held until the next accepted start.
- response  output  CHAIN_LEN  captured response; response[k] = value captured by flop k.

Behaviour:
- Single clock CLK. Reset RN is asynchronous, active-low.
- Reset values: SE=0, SI=0, busy=0, done=0, mismatch=0, response=0, state=IDLE, counter=0.
- Chain topology: flop 0 takes SI, flop k+1 takes Q of flop k, SO is Q of flop CHAIN_LEN-1.
- start is registered together with pattern/expect/mask, which are latched into internal shadow registers. Inputs may change after acceptance.

State machine:
- IDLE
  - SE=0, SI=0.
  - On start: latch the vectors, clear mismatch, load counter=0, go to SHIFT_IN.
  - SE=1 is visible in the first cycle after the accepting edge.
- SHIFT_IN
  - SE=1. In shift cycle i (i=0..CHAIN_LEN-1), SI=pattern[CHAIN_LEN-1-i].
  - After CHAIN_LEN cycles go to CAPTURE. At that point flop k holds pattern[k].
- CAPTURE
  - Exactly one cycle with SE=0 and SI=FILL. The chain captures D at the edge that ends this cycle.
  - Then go to SHIFT_OUT.
- SHIFT_OUT
  - SE=1, SI=FILL.
  - At the edge ending shift cycle j (j=0..CHAIN_LEN-1), SO is sampled into response[CHAIN_LEN-1-j]. The sample is the pre-edge value of SO.
  - After CHAIN_LEN cycles go to DONE.
- DONE
  - SE=0. done=1 for this single cycle.
  - mismatch is registered from the compare of the full response against latched expect/mask, and is valid in the same cycle as done.
  - Then go to IDLE.
- Latency: start-accept edge to done-high cycle is 2*CHAIN_LEN+2 cycles. busy is high for exactly those cycles.

Boundary conditions:
- start while busy: ignored, no effect.
- start and abort in the same IDLE cycle: abort wins, start is dropped.
- abort in any busy state: next cycle is IDLE with SE=0, SI=0, no done pulse. response and mismatch keep their last completed values.
- RN asserted mid-operation: immediate return to reset values. The chain contents are undefined afterwards.
- Counter wraps only by reload on a state change. It never exceeds CHAIN_LEN-1.
- mask=0: mismatch is always 0.
- SE never glitches. SE and SI are driven from flops only.

Decomposition:
- Shared package scan_ctrl_pkg holds:
  - state enum (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE);
  - FILL default;
  - a function for the masked-compare reduction.
- One natural sub-module: scan_shift_reg. It is a parallel-load, serial-in/serial-out shift register of CHAIN_LEN bits, used once for the pattern (MSB-first out) and once for the response (serial in, parallel read).
- The FSM and counter stay in the top module.

Test Plan:
1. Loopback, SO tied to an 8-flop sdffq chain whose D = ~Q, CHAIN_LEN=8, pattern=8'hA5, expect=8'h5A, mask=8'hFF.
   -> response=8'h5A, mismatch=0, done exactly 18 cycles after the accepting edge.
2. Same setup, expect=8'h5B.
   -> mismatch=1. With mask=8'hFE instead -> mismatch=0.
3. Abort asserted in shift cycle 3 of SHIFT_IN.
   -> next cycle SE=0, busy=0, no done pulse, response unchanged from the prior run.
4. RN pulsed low mid-SHIFT_OUT.
   -> SE, SI, busy, done, mismatch, response all 0 asynchronously. A new start then completes normally.
5. start re-asserted every cycle while busy.
   -> only one run. busy high for exactly 2*CHAIN_LEN+2 cycles. A start in the cycle after done is accepted.
6. SE/SI waveform check, pattern=8'h01.
   -> SI high only in SHIFT_IN cycle 7. SE low only in IDLE, CAPTURE and DONE.
